// File: rtl/de2i_150_qsys_fir_engine.sv
// FIR compute engine: reads coefficients/samples from the shared FIR memory port,
// accumulates T products per output, writes saturated results back, flags done.
module de2i_150_qsys_fir_engine #(
    parameter int ACC_W    = 48,
    parameter int MAX_TAPS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    output logic        irq,
    output logic [14:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD_C, S_RD_X, S_MAC, S_WR, S_FIN} state_t;

    localparam logic [10:0]             L_MAX_TAPS = 11'(MAX_TAPS);
    localparam logic signed [ACC_W-1:0] L_POS      = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] L_NEG      = ACC_W'(-32768);

    state_t                  r_state;
    logic                    r_irq_en, r_done;
    logic [14:0]             r_coef_base, r_sample_base, r_result_base;
    logic [10:0]             r_num_taps, r_k;
    logic [15:0]             r_num_out, r_n;
    logic [4:0]              r_shift;
    logic signed [15:0]      r_coef;
    logic signed [ACC_W-1:0] r_acc;
    logic [31:0]             r_csr_rdata, r_mem_wdata;
    logic [14:0]             r_mem_addr;
    logic                    r_mem_cs, r_mem_wr;

    logic                    w_busy, w_wr_ctrl, w_start, w_cfg_ok, w_cfg_wr;
    logic                    w_last_tap, w_last_out;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_nxt, w_shifted;
    logic [15:0]             w_sat;
    logic [10:0]             w_k_inc;
    logic [31:0]             w_rdata;
    logic                    w_unused;

    assign w_busy     = (r_state != S_IDLE);
    assign w_wr_ctrl  = csr_write && (csr_address == 3'd0);
    assign w_start    = w_wr_ctrl && csr_writedata[0] && !w_busy;
    assign w_cfg_wr   = csr_write && !w_busy;
    assign w_cfg_ok   = (r_num_taps != '0) && (r_num_out != '0) && (r_num_taps <= L_MAX_TAPS);
    assign w_last_tap = (r_k == r_num_taps - 11'd1);
    assign w_last_out = (r_n == r_num_out - 16'd1);
    assign w_k_inc    = r_k + 11'd1;

    // Sample arrives on mem_readdata during MAC and is used directly.
    assign w_prod    = r_coef * $signed(mem_readdata[15:0]);
    assign w_acc_nxt = r_acc + ACC_W'(w_prod);
    assign w_shifted = w_acc_nxt >>> r_shift;

    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > L_POS)      w_sat = 16'h7FFF;
        else if (w_shifted < L_NEG) w_sat = 16'h8000;
    end

    always_comb begin
        w_rdata = '0;
        case (csr_address)
            3'd0: w_rdata = {30'b0, r_irq_en, 1'b0};
            3'd1: w_rdata = {30'b0, r_done, w_busy};
            3'd2: w_rdata = {17'b0, r_coef_base};
            3'd3: w_rdata = {17'b0, r_sample_base};
            3'd4: w_rdata = {17'b0, r_result_base};
            3'd5: w_rdata = {21'b0, r_num_taps};
            3'd6: w_rdata = {16'b0, r_num_out};
            3'd7: w_rdata = {27'b0, r_shift};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_coef_base   <= '0;
            r_sample_base <= '0;
            r_result_base <= '0;
            r_num_taps    <= '0;
            r_num_out     <= '0;
            r_shift       <= '0;
            r_csr_rdata   <= '0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= csr_writedata[1];
            // A clear landing in the FIN cycle loses to the set.
            if (r_state == S_FIN)
                r_done <= 1'b1;
            else if (csr_write && (csr_address == 3'd1) && csr_writedata[1])
                r_done <= 1'b0;
            if (w_cfg_wr) begin
                case (csr_address)
                    3'd2: r_coef_base   <= csr_writedata[14:0];
                    3'd3: r_sample_base <= csr_writedata[14:0];
                    3'd4: r_result_base <= csr_writedata[14:0];
                    3'd5: r_num_taps    <= csr_writedata[10:0];
                    3'd6: r_num_out     <= csr_writedata[15:0];
                    3'd7: r_shift       <= csr_writedata[4:0];
                    default: ;
                endcase
            end
            if (csr_read) r_csr_rdata <= w_rdata;
        end
    end

    // Memory strobes are registered: each transition loads the address the next state drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_n         <= '0;
            r_coef      <= '0;
            r_acc       <= '0;
            r_mem_addr  <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_cs <= 1'b0;
            r_mem_wr <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    if (w_cfg_ok) begin
                        r_state    <= S_RD_C;
                        r_k        <= '0;
                        r_n        <= '0;
                        r_acc      <= '0;
                        r_mem_addr <= r_coef_base;
                        r_mem_cs   <= 1'b1;
                    end else begin
                        r_state <= S_FIN;
                    end
                end
                S_RD_C: begin
                    r_state    <= S_RD_X;
                    r_mem_addr <= r_sample_base + r_n[14:0] + 15'(r_k);
                    r_mem_cs   <= 1'b1;
                end
                S_RD_X: begin
                    r_coef  <= $signed(mem_readdata[15:0]);
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc    <= w_acc_nxt;
                    r_mem_cs <= 1'b1;
                    if (w_last_tap) begin
                        r_state     <= S_WR;
                        r_mem_addr  <= r_result_base + r_n[14:0];
                        r_mem_wr    <= 1'b1;
                        r_mem_wdata <= {{16{w_sat[15]}}, w_sat};
                    end else begin
                        r_state    <= S_RD_C;
                        r_k        <= w_k_inc;
                        r_mem_addr <= r_coef_base + 15'(w_k_inc);
                    end
                end
                S_WR: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_last_out) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state    <= S_RD_C;
                        r_n        <= r_n + 16'd1;
                        r_mem_addr <= r_coef_base;
                        r_mem_cs   <= 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign csr_readdata   = r_csr_rdata;
    assign irq            = r_done & r_irq_en;
    assign mem_address    = r_mem_addr;
    assign mem_chipselect = r_mem_cs;
    assign mem_write      = r_mem_wr;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = r_mem_wdata;
    assign mem_clken      = 1'b1;
    assign w_unused       = ^{mem_readdata[31:16], csr_writedata[31:16]};

endmodule

// File: tb/tb_de2i_150_qsys_fir_engine.sv
// Bench for the FIR engine: behavioural 32K memory, scoreboard of expected writes
// (address, data, cycle) pushed at START and popped as the engine writes results.
module tb_de2i_150_qsys_fir_engine;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0, csr_read = 1'b0;
    logic [31:0] csr_writedata = '0, csr_readdata;
    logic        irq;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    de2i_150_qsys_fir_engine dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata), .irq(irq),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    typedef struct { logic [14:0] a; logic [31:0] d; int c; } exp_t;
    exp_t        sb[$];
    logic [31:0] mem [0:32767];
    int cyc = 0, n_cs = 0, n_wr = 0, n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory model (1-cycle read latency) plus write monitor.
    always @(posedge clk) begin
        exp_t e;
        if (mem_chipselect) begin
            n_cs <= n_cs + 1;
            if (mem_write) mem[mem_address] <= mem_writedata;
            mem_readdata <= mem[mem_address];
        end
        if (mem_chipselect && mem_write) begin
            n_wr <= n_wr + 1;
            if (sb.size() == 0) chk("unexpected_write", {17'b0, mem_address}, 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("wr_addr", {17'b0, mem_address}, {17'b0, e.a});
                chk("wr_data", mem_writedata, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] ref_y(input int cb, input int sbase, input int t, input int n, input int sh);
        longint acc = 0;
        for (int k = 0; k < t; k++)
            acc += longint'($signed(mem[15'(cb + k)][15:0])) * longint'($signed(mem[15'(sbase + n + k)][15:0]));
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return 32'(acc);
    endfunction

    task automatic ld(input int a, input int v);
        mem[15'(a)] <= {16'hA5C3, 16'(v)};   // upper half is junk the engine must ignore
    endtask

    task automatic wr(input logic [2:0] a, input int d);
        @(negedge clk); csr_address = a; csr_writedata = 32'(d); csr_write = 1'b1;
        @(negedge clk); csr_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk); csr_address = a; csr_read = 1'b1;
        @(negedge clk); csr_read = 1'b0; d = csr_readdata;
    endtask

    task automatic cfg(input int cb, input int sbase, input int rb, input int t, input int n, input int sh);
        wr(3'd2, cb); wr(3'd3, sbase); wr(3'd4, rb); wr(3'd5, t); wr(3'd6, n); wr(3'd7, sh);
        wr(3'd1, 2);
    endtask

    task automatic start(input int cb, input int sbase, input int rb, input int t, input int n,
                         input int sh, input int n_exp, output int t0);
        exp_t e;
        @(negedge clk); csr_address = 3'd0; csr_writedata = 32'd3; csr_write = 1'b1;
        t0 = cyc;
        for (int i = 0; i < n_exp; i++) begin
            e.a = 15'(rb + i);
            e.d = ref_y(cb, sbase, t, i, sh);
            e.c = t0 + (i + 1) * (3 * t + 1);
            sb.push_back(e);
        end
        @(negedge clk); csr_write = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t_exp);
        int guard = 0;
        while (irq !== 1'b1 && guard < 20000) begin @(negedge clk); guard++; end
        chk({tag, "_done_cycle"}, cyc, t_exp);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_run(input string tag, input int cb, input int sbase, input int rb,
                          input int t, input int n, input int sh);
        int t0, cs0;
        bit degen;
        degen = (t == 0) || (n == 0) || (t > 1024);
        cfg(cb, sbase, rb, t, n, sh);
        cs0 = n_cs;
        start(cb, sbase, rb, t, n, sh, degen ? 0 : n, t0);
        wait_done(tag, degen ? t0 + 2 : t0 + n * (3 * t + 1) + 2);
        chk({tag, "_cs_count"}, n_cs - cs0, degen ? 0 : n * (2 * t + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int t0, wr0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", csr_readdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_be", mem_byteenable, 4'hF);
        chk("rst_clken", mem_clken, 1);
        reset_n = 1'b1;
        rd(3'd1, d); chk("rst_status", d, 0);

        // Single tap, unit gain
        ld(16'h100, 1);
        ld(16'h200, 5); ld(16'h201, -3); ld(16'h202, 32767); ld(16'h203, -32768);
        do_run("unit", 16'h100, 16'h200, 16'h300, 1, 4, 0);
        chk("unit_y0", mem[15'h300], 32'd5);
        chk("unit_y1", mem[15'h301], 32'hFFFF_FFFD);
        chk("unit_y2", mem[15'h302], 32'h0000_7FFF);
        chk("unit_y3", mem[15'h303], 32'hFFFF_8000);

        // 3-tap moving sum
        for (int i = 0; i < 3; i++) ld(16'h110 + i, 1);
        for (int i = 0; i < 6; i++) ld(16'h210 + i, i + 1);
        do_run("msum", 16'h110, 16'h210, 16'h310, 3, 4, 0);
        chk("msum_y0", mem[15'h310], 32'd6);
        chk("msum_y1", mem[15'h311], 32'd9);
        chk("msum_y2", mem[15'h312], 32'd12);
        chk("msum_y3", mem[15'h313], 32'd15);

        // Saturation with shift, both polarities
        ld(16'h120, 16384); ld(16'h121, 16384); ld(16'h220, 32767); ld(16'h221, 32767);
        do_run("satp", 16'h120, 16'h220, 16'h320, 2, 1, 14);
        chk("satp_y", mem[15'h320], 32'h0000_7FFF);
        ld(16'h122, -32768); ld(16'h123, -32768);
        do_run("satn", 16'h122, 16'h220, 16'h321, 2, 1, 15);
        chk("satn_y", mem[15'h321], 32'hFFFF_8000);

        // Sample address wrap
        for (int i = 0; i < 4; i++) ld(16'h130 + i, 1);
        ld(16'h7FFE, 1); ld(16'h7FFF, 2); ld(16'h0000, 3); ld(16'h0001, 4);
        do_run("wrap", 16'h130, 16'h7FFE, 16'h330, 4, 1, 0);
        chk("wrap_y", mem[15'h330], 32'd10);

        // Random data through the reference model
        for (int i = 0; i < 8; i++) mem[15'h400 + 15'(i)] <= $urandom;
        for (int i = 0; i < 12; i++) mem[15'h500 + 15'(i)] <= $urandom;
        do_run("rnd3", 16'h400, 16'h500, 16'h600, 5, 6, 3);
        do_run("rnd20", 16'h400, 16'h500, 16'h610, 5, 6, 20);

        // Degenerate starts: no memory traffic, done at cycle 2
        do_run("t0", 16'h100, 16'h200, 16'h340, 0, 4, 0);
        do_run("n0", 16'h100, 16'h200, 16'h340, 3, 0, 0);
        do_run("tbig", 16'h100, 16'h200, 16'h340, 1025, 1, 0);

        // Writes while busy
        cfg(16'h400, 16'h500, 16'h620, 8, 2, 6);
        start(16'h400, 16'h500, 16'h620, 8, 2, 6, 2, t0);
        wr(3'd2, 16'h1234);
        wr(3'd0, 3);
        rd(3'd2, d); chk("busy_coef_base", d, 32'h400);
        rd(3'd1, d); chk("busy_status", d, 32'd1);
        wr(3'd0, 0);
        rd(3'd0, d); chk("busy_irqen_clr", d, 0);
        wr(3'd0, 2);
        rd(3'd0, d); chk("busy_irqen_set", d, 32'd2);
        wait_done("busy", t0 + 2 * 25 + 2);

        // Clear of done in the FIN cycle loses; irq tracks done
        cfg(16'h100, 16'h200, 16'h700, 1, 1, 0);
        start(16'h100, 16'h200, 16'h700, 1, 1, 0, 1, t0);
        while (cyc < t0 + 5) @(negedge clk);
        csr_address = 3'd1; csr_writedata = 32'd2; csr_write = 1'b1;
        @(negedge clk); csr_write = 1'b0;
        chk("fin_w1c_irq", irq, 1);
        chk("fin_w1c_cycle", cyc, t0 + 6);
        chk("fin_sb_empty", sb.size(), 0);
        rd(3'd1, d); chk("fin_status", d, 32'd2);
        wr(3'd1, 2);
        chk("irq_cleared", irq, 0);
        rd(3'd1, d); chk("status_cleared", d, 0);

        // Reset during RD_X of output 2
        cfg(16'h400, 16'h500, 16'h780, 2, 4, 0);
        start(16'h400, 16'h500, 16'h780, 2, 4, 0, 2, t0);
        while (cyc < t0 + 16) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_cs", mem_chipselect, 0);
        chk("mrst_wr", mem_write, 0);
        chk("mrst_addr", mem_address, 0);
        chk("mrst_wdata", mem_writedata, 0);
        chk("mrst_irq", irq, 0);
        chk("mrst_readdata", csr_readdata, 0);
        chk("mrst_sb_empty", sb.size(), 0);
        wr0 = n_wr;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mrst_no_writes", n_wr - wr0, 0);
        rd(3'd1, d); chk("mrst_status", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
